// File: rtl/nsc8_ctrl_pkg.sv
// Shared definitions for the NSC8 control sequencer: opcodes, FSM states, decode classes, strobes.
// SEQ_SINGLE_STEP_EN adds the PAUSE state used for single-stepping.
package nsc8_ctrl_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDA  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LDB  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_LDIB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_STA  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_DECODE,
    ST_EXEC0,
    ST_EXEC1,
    ST_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } state_e;

  // One-hot instruction class; opcodes 0xA-0xE leave every bit clear.
  typedef struct packed {
    logic nop;
    logic lda;
    logic ldb;
    logic ldib;
    logic add;
    logic sub;
    logic sta;
    logic jmp;
    logic jz;
    logic out;
    logic hlt;
  } instr_class_t;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic load_pc;
    logic load_mar;
    logic ram_out;
    logic ram_write;
    logic load_ir;
    logic ir_out;
    logic load_a;
    logic a_out;
    logic load_b;
    logic load_immediate_b;
    logic alu_out;
    logic alu_sub;
    logic load_flags;
    logic load_out;
  } strobe_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bundle: status inputs and one-bit control strobes.
// SEQ_SINGLE_STEP_EN adds the step request.
interface control_sequencer_if #(
  parameter int unsigned N = 8
);

  logic         run;
`ifdef SEQ_SINGLE_STEP_EN
  logic         step;
`endif
  logic [N-1:0] instr;
  logic         zero_flag;

  logic pc_out;
  logic pc_inc;
  logic load_pc;
  logic load_mar;
  logic ram_out;
  logic ram_write;
  logic load_ir;
  logic ir_out;
  logic load_a;
  logic a_out;
  logic load_b;
  logic load_immediate_b;
  logic alu_out;
  logic alu_sub;
  logic load_flags;
  logic load_out;
  logic halted;

  modport master (
    input  run,
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    input  instr, zero_flag,
    output pc_out, pc_inc, load_pc, load_mar, ram_out, ram_write, load_ir, ir_out,
           load_a, a_out, load_b, load_immediate_b, alu_out, alu_sub, load_flags,
           load_out, halted
  );

  modport slave (
    output run,
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    output instr, zero_flag,
    input  pc_out, pc_inc, load_pc, load_mar, ram_out, ram_write, load_ir, ir_out,
           load_a, a_out, load_b, load_immediate_b, alu_out, alu_sub, load_flags,
           load_out, halted
  );

endinterface

// File: rtl/control_sequencer_opcode_decoder.sv
// Maps an opcode to its one-hot instruction class.
module opcode_decoder
  import nsc8_ctrl_pkg::*;
#(
  parameter int unsigned W = OPCODE_W
) (
  input  logic [W-1:0] opcode,
  output instr_class_t iclass_c
);

  always_comb begin
    iclass_c = '0;
    case (opcode)
      W'(OP_NOP):  iclass_c.nop  = 1'b1;
      W'(OP_LDA):  iclass_c.lda  = 1'b1;
      W'(OP_LDB):  iclass_c.ldb  = 1'b1;
      W'(OP_LDIB): iclass_c.ldib = 1'b1;
      W'(OP_ADD):  iclass_c.add  = 1'b1;
      W'(OP_SUB):  iclass_c.sub  = 1'b1;
      W'(OP_STA):  iclass_c.sta  = 1'b1;
      W'(OP_JMP):  iclass_c.jmp  = 1'b1;
      W'(OP_JZ):   iclass_c.jz   = 1'b1;
      W'(OP_OUT):  iclass_c.out  = 1'b1;
      W'(OP_HLT):  iclass_c.hlt  = 1'b1;
      default:     iclass_c      = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for the NSC8 CPU: fetch/decode/execute FSM driving datapath strobes.
// Optional SEQ_SINGLE_STEP_EN parks in PAUSE after each instruction until step is seen.
module control_sequencer
  import nsc8_ctrl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  control_sequencer_if.master  bus
);

  localparam int unsigned OPC_W = N / 2;

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_e ST_RESUME = ST_PAUSE;
`else
  localparam state_e ST_RESUME = ST_FETCH0;
`endif

  state_e       state_q;
  state_e       state_d;
  instr_class_t ic;
  strobe_t      sb;
  logic         unused_operand;

  // Operand bits are consumed by the datapath, never by the sequencer.
  assign unused_operand = ^bus.instr[OPC_W-1:0];

  opcode_decoder #(.W(OPC_W)) u_dec (
    .opcode   (bus.instr[N-1:OPC_W]),
    .iclass_c (ic)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sb      = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH0;
      end
      ST_FETCH0: begin
        sb.pc_out   = 1'b1;
        sb.load_mar = 1'b1;
        state_d     = ST_FETCH1;
      end
      ST_FETCH1: begin
        sb.ram_out = 1'b1;
        sb.load_ir = 1'b1;
        sb.pc_inc  = 1'b1;
        state_d    = ST_DECODE;
      end
      ST_DECODE: begin
        if (ic.nop)      state_d = ST_RESUME;
        else if (ic.hlt) state_d = ST_HALT;
        else             state_d = ST_EXEC0;
      end
      ST_EXEC0: begin
        // Undefined opcodes fall through with no strobes.
        state_d = ST_RESUME;
        if (ic.lda || ic.ldb || ic.sta) begin
          sb.ir_out   = 1'b1;
          sb.load_mar = 1'b1;
          state_d     = ST_EXEC1;
        end
        if (ic.ldib) begin
          sb.ir_out           = 1'b1;
          sb.load_immediate_b = 1'b1;
        end
        if (ic.add || ic.sub) begin
          sb.alu_out    = 1'b1;
          sb.load_a     = 1'b1;
          sb.load_flags = 1'b1;
          sb.alu_sub    = ic.sub;
        end
        if (ic.jmp) begin
          sb.ir_out  = 1'b1;
          sb.load_pc = 1'b1;
        end
        if (ic.jz) begin
          sb.ir_out  = 1'b1;
          sb.load_pc = bus.zero_flag;
        end
        if (ic.out) begin
          sb.a_out    = 1'b1;
          sb.load_out = 1'b1;
        end
      end
      ST_EXEC1: begin
        state_d = ST_RESUME;
        if (ic.lda) begin
          sb.ram_out = 1'b1;
          sb.load_a  = 1'b1;
        end
        if (ic.ldb) begin
          sb.ram_out = 1'b1;
          sb.load_b  = 1'b1;
        end
        if (ic.sta) begin
          sb.a_out     = 1'b1;
          sb.ram_write = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (bus.step) state_d = ST_FETCH0;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pc_out           = sb.pc_out;
  assign bus.pc_inc           = sb.pc_inc;
  assign bus.load_pc          = sb.load_pc;
  assign bus.load_mar         = sb.load_mar;
  assign bus.ram_out          = sb.ram_out;
  assign bus.ram_write        = sb.ram_write;
  assign bus.load_ir          = sb.load_ir;
  assign bus.ir_out           = sb.ir_out;
  assign bus.load_a           = sb.load_a;
  assign bus.a_out            = sb.a_out;
  assign bus.load_b           = sb.load_b;
  assign bus.load_immediate_b = sb.load_immediate_b;
  assign bus.alu_out          = sb.alu_out;
  assign bus.alu_sub          = sb.alu_sub;
  assign bus.load_flags       = sb.load_flags;
  assign bus.load_out         = sb.load_out;
  assign bus.halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction micro-step model plus directed vectors.
module tb_control_sequencer;

  localparam logic [15:0] S_PC_OUT     = 16'h8000;
  localparam logic [15:0] S_PC_INC     = 16'h4000;
  localparam logic [15:0] S_LOAD_PC    = 16'h2000;
  localparam logic [15:0] S_LOAD_MAR   = 16'h1000;
  localparam logic [15:0] S_RAM_OUT    = 16'h0800;
  localparam logic [15:0] S_RAM_WRITE  = 16'h0400;
  localparam logic [15:0] S_LOAD_IR    = 16'h0200;
  localparam logic [15:0] S_IR_OUT     = 16'h0100;
  localparam logic [15:0] S_LOAD_A     = 16'h0080;
  localparam logic [15:0] S_A_OUT      = 16'h0040;
  localparam logic [15:0] S_LOAD_B     = 16'h0020;
  localparam logic [15:0] S_LOAD_IMMB  = 16'h0010;
  localparam logic [15:0] S_ALU_OUT    = 16'h0008;
  localparam logic [15:0] S_ALU_SUB    = 16'h0004;
  localparam logic [15:0] S_LOAD_FLAGS = 16'h0002;
  localparam logic [15:0] S_LOAD_OUT   = 16'h0001;
  localparam logic [15:0] DRIVERS = S_PC_OUT | S_RAM_OUT | S_IR_OUT | S_A_OUT | S_ALU_OUT;
  localparam logic [15:0] V_FETCH0 = S_PC_OUT | S_LOAD_MAR;

`ifdef SEQ_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
  localparam int X = 1;
`else
  localparam bit STEP_EN = 1'b0;
  localparam int X = 0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_PAUSE = 3;

  logic clk;
  logic reset;
  logic step_in;
  bit   done;
  int   checks;
  int   errors;

  control_sequencer_if #(.N(8)) bus ();
`ifdef SEQ_SINGLE_STEP_EN
  assign bus.step = step_in;
`endif

  control_sequencer #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {bus.pc_out, bus.pc_inc, bus.load_pc, bus.load_mar, bus.ram_out,
                    bus.ram_write, bus.load_ir, bus.ir_out, bus.load_a, bus.a_out,
                    bus.load_b, bus.load_immediate_b, bus.alu_out, bus.alu_sub,
                    bus.load_flags, bus.load_out};

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycles from one FETCH0 to the next, by opcode.
  function automatic int lat(input logic [3:0] op);
    case (op)
      4'h0, 4'hF:       return 3;
      4'h1, 4'h2, 4'h6: return 5;
      default:          return 4;
    endcase
  endfunction

  // Strobes expected at micro-step p of an instruction.
  function automatic logic [15:0] micro(input logic [3:0] op, input int p, input logic zf);
    case (p)
      0: return V_FETCH0;
      1: return S_RAM_OUT | S_LOAD_IR | S_PC_INC;
      3: case (op)
           4'h1, 4'h2, 4'h6: return S_IR_OUT | S_LOAD_MAR;
           4'h3: return S_IR_OUT | S_LOAD_IMMB;
           4'h4: return S_ALU_OUT | S_LOAD_A | S_LOAD_FLAGS;
           4'h5: return S_ALU_OUT | S_LOAD_A | S_LOAD_FLAGS | S_ALU_SUB;
           4'h7: return S_IR_OUT | S_LOAD_PC;
           4'h8: return S_IR_OUT | (zf ? S_LOAD_PC : 16'h0000);
           4'h9: return S_A_OUT | S_LOAD_OUT;
           default: return 16'h0000;
         endcase
      4: case (op)
           4'h1: return S_RAM_OUT | S_LOAD_A;
           4'h2: return S_RAM_OUT | S_LOAD_B;
           4'h6: return S_A_OUT | S_RAM_WRITE;
           default: return 16'h0000;
         endcase
      default: return 16'h0000;
    endcase
  endfunction

  int m_mode;
  int m_p;
  initial begin
    m_mode = M_IDLE;
    m_p    = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= M_IDLE;
      m_p    <= 0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.run) begin m_mode <= M_RUN; m_p <= 0; end
        M_RUN: begin
          if (m_p == 2 && bus.instr[7:4] == 4'hF) m_mode <= M_HALT;
          else if (m_p + 1 >= lat(bus.instr[7:4])) begin
            m_p <= 0;
            if (STEP_EN) m_mode <= M_PAUSE;
          end else m_p <= m_p + 1;
        end
        M_PAUSE: if (step_in) begin m_mode <= M_RUN; m_p <= 0; end
        default: ;
      endcase
    end
  end

  logic [15:0] exp_vec;
  assign exp_vec = (m_mode == M_RUN) ? micro(bus.instr[7:4], m_p, bus.zero_flag) : 16'h0000;

  always @(negedge clk) begin
    if (!done) begin
      check("model_strobes", dut_vec, exp_vec);
      check("model_halted", {15'b0, bus.halted}, {15'b0, m_mode == M_HALT});
      check("one_bus_driver", {15'b0, $countones(dut_vec & DRIVERS) <= 1}, 16'h0001);
      check("b_load_exclusive", {15'b0, bus.load_b & bus.load_immediate_b}, 16'h0000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH0; runs one instruction until the next FETCH0 or HALT.
  task automatic run_instr(input logic [7:0] ins, input logic zf, output int n,
                           output logic [15:0] e0, output logic [15:0] e1);
    bit fin;
    bus.instr     = ins;
    bus.zero_flag = zf;
    n = 0; e0 = '0; e1 = '0; fin = 1'b0;
    while (n < 30 && !fin) begin
      tick();
      n++;
      if (n == 3) e0 = dut_vec;
      if (n == 4) e1 = dut_vec;
      fin = (dut_vec == V_FETCH0) || bus.halted;
    end
    check("instr_done_in_budget", {15'b0, fin}, 16'h0001);
  endtask

  typedef struct {
    logic [7:0]  ins;
    logic        zf;
    logic [15:0] e0;
    logic [15:0] e1;
    int          len;
  } vec_t;

  vec_t tbl[11];
  int          n;
  logic [15:0] e0;
  logic [15:0] e1;

  initial begin
    tbl[0]  = '{8'h35, 1'b0, S_IR_OUT | S_LOAD_IMMB, 16'h0, 4};
    tbl[1]  = '{8'h2A, 1'b0, S_IR_OUT | S_LOAD_MAR, S_RAM_OUT | S_LOAD_B, 5};
    tbl[2]  = '{8'h84, 1'b0, S_IR_OUT, 16'h0, 4};
    tbl[3]  = '{8'h84, 1'b1, S_IR_OUT | S_LOAD_PC, 16'h0, 4};
    tbl[4]  = '{8'h40, 1'b0, S_ALU_OUT | S_LOAD_A | S_LOAD_FLAGS, 16'h0, 4};
    tbl[5]  = '{8'h51, 1'b1, S_ALU_OUT | S_LOAD_A | S_LOAD_FLAGS | S_ALU_SUB, 16'h0, 4};
    tbl[6]  = '{8'h7C, 1'b0, S_IR_OUT | S_LOAD_PC, 16'h0, 4};
    tbl[7]  = '{8'h93, 1'b0, S_A_OUT | S_LOAD_OUT, 16'h0, 4};
    tbl[8]  = '{8'h1F, 1'b0, S_IR_OUT | S_LOAD_MAR, S_RAM_OUT | S_LOAD_A, 5};
    tbl[9]  = '{8'h00, 1'b0, 16'h0, 16'h0, 3};
    tbl[10] = '{8'hB7, 1'b1, 16'h0, 16'h0, 4};

    checks = 0; errors = 0; done = 1'b0;
    reset = 1'b1; step_in = 1'b1;
    bus.run = 1'b0; bus.instr = 8'h00; bus.zero_flag = 1'b0;
    repeat (3) tick();
    check("reset_strobes", dut_vec, 16'h0000);
    check("reset_halted", {15'b0, bus.halted}, 16'h0000);
    bus.run = 1'b1;
    tick();
    check("run_during_reset", dut_vec, 16'h0000);
    bus.run = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_strobes", dut_vec, 16'h0000);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    check("fetch0_after_run", dut_vec, V_FETCH0);

    foreach (tbl[i]) begin
      run_instr(tbl[i].ins, tbl[i].zf, n, e0, e1);
      if (tbl[i].len > 3) check($sformatf("exec0_%h_zf%0d", tbl[i].ins, tbl[i].zf), e0, tbl[i].e0);
      if (tbl[i].len == 5) check($sformatf("exec1_%h", tbl[i].ins), e1, tbl[i].e1);
      check($sformatf("latency_%h", tbl[i].ins), 16'(n), 16'(tbl[i].len + X));
    end

    // Reset in EXEC1 of STA abandons the store.
    bus.instr = 8'h6C;
    repeat (4) tick();
    check("sta_exec1", dut_vec, S_A_OUT | S_RAM_WRITE);
    reset = 1'b1;
    tick();
    check("sta_reset_strobes", dut_vec, 16'h0000);
    reset = 1'b0;
    tick();
    check("idle_after_sta_reset", dut_vec, 16'h0000);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    check("restart_fetch0", dut_vec, V_FETCH0);

`ifdef SEQ_SINGLE_STEP_EN
    step_in = 1'b0;
    bus.instr = 8'h40;
    repeat (3) tick();
    check("step_exec0_add", dut_vec, S_ALU_OUT | S_LOAD_A | S_LOAD_FLAGS);
    tick();
    check("pause_entered", dut_vec, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pause_hold", dut_vec, 16'h0000);
    end
    step_in = 1'b1;
    tick();
    check("step_to_fetch0", dut_vec, V_FETCH0);
`endif

    run_instr(8'hF0, 1'b0, n, e0, e1);
    check("hlt_halted", {15'b0, bus.halted}, 16'h0001);
    check("hlt_latency", 16'(n), 16'd3);
    for (int i = 0; i < 20; i++) begin
      bus.run = i[0];
      tick();
      check("halt_hold", {dut_vec[15:1], bus.halted}, 16'h0001);
    end
    bus.run = 1'b0;
    reset = 1'b1;
    tick();
    check("halt_reset", {15'b0, bus.halted}, 16'h0000);
    reset = 1'b0;
    tick();
    check("idle_after_halt", {dut_vec[15:1], bus.halted}, 16'h0000);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, datapath width; instruction opcode = instr[N-1:N/2], operand = instr[N/2-1:0].
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port run  input  1  start request, sampled in IDLE.
REQ-005 SHALL have port instr  input  N  instruction register contents.
REQ-006 SHALL have port zero_flag  input  1  ALU zero flag, sampled in EXEC0.
REQ-007 SHALL have output strobes, each 1 bit, active-high: pc_out, pc_inc, load_pc, load_mar, ram_out, ram_write, load_ir, ir_out, load_a, a_out, load_b, load_immediate_b, alu_out, alu_sub, load_flags, load_out.
REQ-008 SHALL have port halted  output  1  high in HALT state.

Function
REQ-009 SHALL be a Moore FSM with states IDLE, FETCH0, FETCH1, DECODE, EXEC0, EXEC1, HALT; strobes decoded combinationally from registered state and instr.
REQ-010 IDLE: no strobes; run=1 -> FETCH0, else stay.
REQ-011 FETCH0: pc_out, load_mar -> FETCH1.
REQ-012 FETCH1: ram_out, load_ir, pc_inc -> DECODE.
REQ-013 DECODE: no strobes; opcode 0x0 (NOP) -> FETCH0; 0xF (HLT) -> HALT; else -> EXEC0.
REQ-014 EXEC0 per opcode: 0x1 LDA / 0x2 LDB / 0x6 STA: ir_out, load_mar -> EXEC1; 0x3 LDIB: ir_out, load_immediate_b -> FETCH0; 0x4 ADD: alu_out, load_a, load_flags -> FETCH0; 0x5 SUB: as ADD plus alu_sub; 0x7 JMP: ir_out, load_pc -> FETCH0; 0x8 JZ: ir_out, load_pc only if zero_flag=1 -> FETCH0; 0x9 OUT: a_out, load_out -> FETCH0.
REQ-015 Undefined opcodes (0xA-0xE) SHALL behave as NOP: no strobes in EXEC0, -> FETCH0.
REQ-016 EXEC1: LDA: ram_out, load_a; LDB: ram_out, load_b; STA: a_out, ram_write; all -> FETCH0.
REQ-017 At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) SHALL be high in any cycle; load_b and load_immediate_b SHALL never be high together.
REQ-018 Instruction latency SHALL be: NOP 3 cycles, LDIB/ADD/SUB/JMP/JZ/OUT 4, LDA/LDB/STA 5, counted FETCH0 to next FETCH0.
REQ-019 HALT: no strobes, halted=1, stay until reset; run ignored.
REQ-020 run SHALL be ignored in all states except IDLE.

Reset
REQ-021 reset=1 at any edge, in any state, SHALL force IDLE next cycle; instruction in flight abandoned.
REQ-022 During and after reset, all strobes and halted SHALL be 0 until run is accepted.

Configuration
REQ-023 When SEQ_SINGLE_STEP_EN is defined: add input step (1 bit) and state PAUSE; every transition that would enter FETCH0 from DECODE, EXEC0 or EXEC1 SHALL enter PAUSE instead; PAUSE emits no strobes and goes to FETCH0 the cycle after step=1.
REQ-024 When SEQ_SINGLE_STEP_EN is undefined: no step port, no PAUSE state, behaviour exactly per REQ-009..REQ-020.
REQ-025 IDLE->FETCH0 via run SHALL be unaffected by SEQ_SINGLE_STEP_EN.

Structure
REQ-026 Package nsc8_ctrl_pkg SHALL hold opcode constants (NOP..HLT) and the state encoding enum.
REQ-027 One sub-module, opcode_decoder, SHALL map opcode to one-hot instruction-class signals used by the FSM.

Verification
REQ-028 reset, run=1 one cycle, instr=0x35 at FETCH1 -> DECODE, EXEC0 with ir_out=1, load_immediate_b=1, load_b=0; FETCH0 on cycle 5 after run.
REQ-029 instr=0x2A -> EXEC0 ir_out+load_mar; EXEC1 ram_out+load_b; next FETCH0 5 cycles after prior FETCH0.
REQ-030 instr=0x84 with zero_flag=0 -> EXEC0 ir_out=1, load_pc=0; repeat with zero_flag=1 -> load_pc=1.
REQ-031 instr=0xF0 -> HALT, halted=1 held for 20 cycles with run toggling; reset=1 -> IDLE, halted=0.
REQ-032 reset=1 asserted during EXEC1 of STA (0x6C) -> ram_write=0 next cycle, state IDLE, all strobes 0.
REQ-033 SEQ_SINGLE_STEP_EN defined, instr=0x40 -> PAUSE after EXEC0, holds 10 cycles with step=0; step=1 -> FETCH0 next cycle.
